ram_bus_bridge: RTL and testbench

RAM_BUS_BRIDGE -- requirements
Module: ram_bus_bridge

---
 rtl/ram_bridge_pkg.sv | 16 +
 rtl/ram_be_merge.sv | 21 ++
 rtl/ram_bus_bridge.sv | 146 ++++++++++++++
 tb/tb_ram_bus_bridge.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bridge_pkg.sv
// Shared types and constants for the request-bus to single-port RAM bridge.
package ram_bridge_pkg;

    localparam int MEM_WORDS_DEFAULT = 1024;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

    // True when a write touches some but not all bytes and so needs read-modify-write.
    function automatic logic is_partial_be(input logic [3:0] be);
        return (be != 4'h0) && (be != 4'hF);
    endfunction

endpackage

// File: rtl/ram_be_merge.sv
// Combinational byte-lane merge: each enabled lane takes the new byte, the rest keep the old.
module ram_be_merge (
    input  logic [31:0] old_data,
    input  logic [31:0] new_data,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    // Per-byte select between stored word and write data.
    always_comb begin
        merged = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_bus_bridge.sv
// Single-outstanding request/response bridge onto a 1-cycle-latency no-change RAM,
// with read-modify-write for partial byte-enable writes and range checking.
module ram_bus_bridge
    import ram_bridge_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_dout
);

    state_e      state_r;
    logic        rsp_valid_r;
    logic        rsp_err_r;
    logic        rsp_is_read_r;
    logic [29:0] addr_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;

    logic        req_ready_s;
    logic        accept_s;
    logic        in_range_s;
    logic [31:0] merged_s;
    logic        unused_s;

    assign unused_s = ^req_addr[1:0];

    // Gating with rstn keeps the bridge from advertising readiness while held in reset.
    assign req_ready_s = rstn && (state_r == IDLE) && (!rsp_valid_r || rsp_ready);
    assign accept_s    = req_valid && req_ready_s;
    assign in_range_s  = ({2'b00, req_addr[31:2]} < 32'(MEM_WORDS));

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    // RAM output is passed straight through; no access is issued while a read is pending.
    assign rsp_rdata = (rsp_valid_r && rsp_is_read_r) ? ram_dout : 32'h0000_0000;

    ram_be_merge u_merge (
        .old_data (ram_dout),
        .new_data (wdata_r),
        .be       (be_r),
        .merged   (merged_s)
    );

    // RAM port drive: accepted request in IDLE, merged write-back in RMW_WR.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = {req_addr[31:2], 2'b00};
        ram_di   = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (accept_s && in_range_s) begin
                    if (!req_we) begin
                        ram_en = 1'b1;
                    end else if (req_be == 4'hF) begin
                        ram_en = 1'b1;
                        ram_we = 1'b1;
                        ram_di = req_wdata;
                    end else if (req_be != 4'h0) begin
                        ram_en = 1'b1;
                    end else begin
                        ram_en = 1'b0;
                    end
                end else begin
                    ram_en = 1'b0;
                end
            end
            RMW_WR: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = {addr_r, 2'b00};
                ram_di   = merged_s;
            end
            default: begin
                ram_en = 1'b0;
            end
        endcase
    end

    // Bridge FSM and response registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= IDLE;
            rsp_valid_r   <= 1'b0;
            rsp_err_r     <= 1'b0;
            rsp_is_read_r <= 1'b0;
            addr_r        <= 30'h0;
            be_r          <= 4'h0;
            wdata_r       <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (req_we && in_range_s && is_partial_be(req_be)) begin
                            state_r       <= RMW_WR;
                            addr_r        <= req_addr[31:2];
                            be_r          <= req_be;
                            wdata_r       <= req_wdata;
                            rsp_valid_r   <= 1'b0;
                            rsp_err_r     <= 1'b0;
                            rsp_is_read_r <= 1'b0;
                        end else begin
                            rsp_valid_r   <= 1'b1;
                            rsp_err_r     <= !in_range_s;
                            rsp_is_read_r <= !req_we && in_range_s;
                        end
                    end else if (rsp_valid_r && rsp_ready) begin
                        rsp_valid_r   <= 1'b0;
                        rsp_err_r     <= 1'b0;
                        rsp_is_read_r <= 1'b0;
                    end else begin
                        rsp_valid_r <= rsp_valid_r;
                    end
                end
                RMW_WR: begin
                    state_r       <= IDLE;
                    rsp_valid_r   <= 1'b1;
                    rsp_err_r     <= 1'b0;
                    rsp_is_read_r <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Directed-vector bench for ram_bus_bridge with a response scoreboard and a behavioural RAM.
module tb_ram_bus_bridge;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_di;
    logic [31:0] ram_dout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [32:0] sb[$];
    logic [31:0] mem [0:1023];

    ram_bus_bridge #(.MEM_WORDS(1024)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_di    (ram_di),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // No-change single-port RAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[11:2]] <= ram_di;
            else        ram_dout <= mem[ram_addr[11:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every completed response handshake is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rstn && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e[31:0]);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
            end
        end
    end

    // Drive one request, check the RAM strobes on the accept cycle, optionally queue its response.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic exp_en, input logic exp_we,
                         input logic push, input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 20);
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            check("ram_en", {31'd0, ram_en}, {31'd0, exp_en});
            check("ram_we", {31'd0, ram_we}, {31'd0, exp_we});
            if (exp_en) check("ram_addr", ram_addr, {addr[31:2], 2'b00});
            if (exp_en && exp_we) check("ram_di", ram_di, wdata);
            if (push) sb.push_back({exp_err, exp_rdata});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rstn = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0;
        req_be = 4'h0; req_wdata = 32'h0; rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("rst_ram_en",    {31'd0, ram_en},    32'd0);
        check("rst_ram_we",    {31'd0, ram_we},    32'd0);
        check("rst_rsp_rdata", rsp_rdata,          32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // Preload via full writes, then read back.
        issue(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
        issue(1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 32'h13, 4'h0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // Partial write: read in T, merged write in T+1.
        issue(1'b1, 32'h20, 4'b0011, 32'h1234_ABCD, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        check("rmw_ram_en", {31'd0, ram_en}, 32'd1);
        check("rmw_ram_we", {31'd0, ram_we}, 32'd1);
        check("rmw_ram_addr", ram_addr, 32'h20);
        check("rmw_ram_di", ram_di, 32'hFFFF_ABCD);
        check("rmw_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        issue(1'b0, 32'h20, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hFFFF_ABCD, 1'b0);

        // Zero byte-enable write and out-of-range accesses make no RAM access.
        issue(1'b1, 32'h20, 4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 32'h20, 4'h0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hFFFF_ABCD, 1'b0);
        issue(1'b0, 32'h1000, 4'h0, 32'h0,       1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
        issue(1'b1, 32'h1004, 4'hF, 32'h5555_5555, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
        idle(2);

        // Backpressure: response held 5 cycles, then handshake and new accept together.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        @(negedge clk);
        check("hold_first_accept", {31'd0, req_ready & ram_en}, 32'd1);
        sb.push_back({1'b0, 32'hDEAD_BEEF});
        @(posedge clk); #1;
        req_addr = 32'h20;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            check("hold_ram_en",    {31'd0, ram_en},    32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release_req_ready", {31'd0, req_ready}, 32'd1);
        check("release_ram_en",    {31'd0, ram_en},    32'd1);
        check("release_ram_addr",  ram_addr,           32'h20);
        sb.push_back({1'b0, 32'hFFFF_ABCD});
        @(posedge clk); #1;
        req_valid = 1'b0;
        idle(2);

        // Back-to-back full writes then reads, one accept per cycle.
        c0 = cyc;
        issue(1'b1, 32'h0, 4'hF, 32'h1111_1111, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
        issue(1'b1, 32'h4, 4'hF, 32'h2222_2222, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
        issue(1'b1, 32'h8, 4'hF, 32'h3333_3333, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
        issue(1'b1, 32'hC, 4'hF, 32'h4444_4444, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 1'b0);
        issue(1'b0, 32'h4, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h2222_2222, 1'b0);
        issue(1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h3333_3333, 1'b0);
        issue(1'b0, 32'hC, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4444_4444, 1'b0);
        check("b2b_cycles", 32'(cyc - c0), 32'd8);
        idle(2);

        // Reset while in RMW_WR abandons the write and produces no response.
        issue(1'b1, 32'h0, 4'b0001, 32'h0000_00AA, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        check("rmw_rst_ram_we",    {31'd0, ram_we},    32'd0);
        check("rmw_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rmw_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rmw_rst_no_rsp",    {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        idle(2);
        issue(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 1'b0);

        idle(4);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
